// File: rtl/sn_pkg.sv
// sn_pkg: shared types and helpers for the stochastic stream generator
package sn_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [3:0] SEED_DEF = 4'h1;
  function automatic logic [3:0] to_offset(input logic [3:0] x);
    return {~x[3], x[2:0]};
  endfunction
  function automatic logic [3:0] rotl(input logic [3:0] v, input int k);
    logic [7:0] d;
    d = {v, v} << (k % 4);
    return d[7:4];
  endfunction
endpackage

// File: rtl/sn_lfsr.sv
// sn_lfsr: 4-bit x^4+x^3+1 LFSR; SNG_DEBRUIJN_EN inserts 0000 after 1000 for a 16-state cycle
module sn_lfsr
  import sn_pkg::*;
#(
  parameter logic [3:0] RST_VAL = SEED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] seed,
  input  logic       step,
  output logic [3:0] q
);
  logic fb;
`ifdef SNG_DEBRUIJN_EN
  assign fb = q[3] ^ q[2] ^ (q[2:0] == 3'b000);
`else
  assign fb = q[3] ^ q[2];
`endif
  // shift register: seed on load, advance on step
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= RST_VAL;
    else if (load) q <= seed;
    else if (step) q <= {q[2:0], fb};
endmodule

// File: rtl/sn_stream_gen.sv
// sn_stream_gen: binary-to-bipolar-stochastic encoder, LANES streams; SNG_DEBRUIJN_EN selects 16-state sequence
module sn_stream_gen
  import sn_pkg::*;
#(
  parameter int         LANES = 4,
  parameter int         LEN_W = 4,
  parameter logic [3:0] SEED  = SEED_DEF
) (
  input  logic                  i_clk_sng,
  input  logic                  i_rst_n_sng,
  input  logic                  i_valid_sng,
  output logic                  o_ready_sng,
  input  logic [LANES-1:0][3:0] i_x_sng,
  input  logic [LEN_W-1:0]      i_len_sng,
  output logic                  o_sn_valid_sng,
  input  logic                  i_sn_ready_sng,
  output logic [LANES-1:0]      o_sn_bit_sng,
  output logic                  o_last_sng
);
  state_t state, state_nx;
  logic [LANES-1:0][3:0] xoff;
  logic [LEN_W-1:0] len_q, cnt;
  logic [3:0] lfsr;
  logic run, accept, xfer;
  assign run    = state == RUN;
  assign accept = i_valid_sng & o_ready_sng;
  assign xfer   = o_sn_valid_sng & i_sn_ready_sng;
  // state register
  always_ff @(posedge i_clk_sng or negedge i_rst_n_sng)
    if (!i_rst_n_sng) state <= IDLE;
    else state <= state_nx;
  // next state: start on accept, finish when the last bit is taken
  always_comb begin
    state_nx = state;
    if (!run) state_nx = accept ? RUN : IDLE;
    else state_nx = (xfer & o_last_sng) ? IDLE : RUN;
  end
  // handshake outputs derived from state and counter
  always_comb begin
    o_ready_sng    = !run;
    o_sn_valid_sng = run;
    o_last_sng     = run & (cnt == len_q);
  end
  // operands latched on accept; counter advances per transferred bit
  always_ff @(posedge i_clk_sng or negedge i_rst_n_sng)
    if (!i_rst_n_sng) begin
      xoff  <= '0;
      len_q <= '0;
      cnt   <= '0;
    end else if (accept) begin
      for (int i = 0; i < LANES; i++) xoff[i] <= to_offset(i_x_sng[i]);
      len_q <= i_len_sng;
      cnt   <= '0;
    end else if (xfer) cnt <= cnt + 1'b1;
  sn_lfsr #(.RST_VAL(SEED)) u_lfsr (
    .clk  (i_clk_sng),
    .rst_n(i_rst_n_sng),
    .load (accept),
    .seed (SEED),
    .step (xfer),
    .q    (lfsr)
  );
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign o_sn_bit_sng[k] = run & (rotl(lfsr, k) < xoff[k]);
  end
endmodule
